reg_file_rename: RTL
====================

// Module: reg_file_rename
// PURPOSE
// Architectural register file plus rename table (busy bit + ROB tag per register) for the Tomasulo core.
// Receiving end of the ROB commit interface: retires committed values into the register state.
// Also serves dispatcher source-operand lookups and rd renaming.
// Sits between Dispatcher (rename/read) and ROB (commit); flushed by the ROB refresh broadcast on the CDB.
// PARAMETERS
// REG_NUM   32  number of architectural registers; x0 hardwired to zero
// REG_W     5   register index width
// DATA_W    32  register data width
// ROB_W     4   ROB id width; id 0 is never allocated and means "no tag"
// PORTS
// clk_in             in   1       clock
// rst_in             in   1       synchronous active-high reset
// rdy_in             in   1       global enable; low = hold all state
// rdy_commit_rob_in  in   1       commit valid, one-cycle pulse from ROB
// dest_rob_in        in   REG_W   committed destination register
// value_rob_in       in   DATA_W  committed value
// rob_id_rob_in      in   ROB_W   ROB id of committing entry
// refresh_cdb_in     in   1       mispredict/jump flush
// rdy_dp_in          in   1       dispatcher renames rd this cycle
// rd_dp_in           in   REG_W   register being renamed
// rob_id_dp_in       in   ROB_W   ROB id allocated to the new producer
// rs1_dp_in          in   REG_W   source 1 index
// rs2_dp_in          in   REG_W   source 2 index
// rs1_busy_dp_out    out  1       rs1 awaits an in-flight producer
// rs1_rob_dp_out     out  ROB_W   rs1 producer tag; 0 when not busy
// rs1_val_dp_out     out  DATA_W  rs1 architectural value
// rs2_busy_dp_out    out  1       as rs1
// rs2_rob_dp_out     out  ROB_W   as rs1
// rs2_val_dp_out     out  DATA_W  as rs1
// BEHAVIOUR
// - State: val[REG_NUM], busy[REG_NUM], tag[REG_NUM]. Read outputs are combinational from state.
// - Reset: all val=0, busy=0, tag=0. Read outputs therefore give busy=0, rob=0, val=0.
// - Priority: rst_in > !rdy_in (hold) > refresh_cdb_in > normal operation.
// - Commit, when rdy_commit_rob_in and dest!=0:
//   - Always performed: val[dest] <= value.
//   - Busy and tag clear only if tag[dest]==rob_id_rob_in (latest producer). Stale commits write the value only.
// - Rename, when rdy_dp_in and rd!=0: busy[rd] <= 1, tag[rd] <= rob_id_dp_in.
// - Same-cycle commit and rename of the same reg: rename wins for busy/tag, and the value write still happens.
// - Refresh cycle:
//   - All busy and tag cleared.
//   - A concurrent commit still writes val; the ROB pulses the commit of the jump together with the refresh.
//   - Rename ignored.
// - x0: never written, never busy; reads always return busy=0, rob=0, val=0.
// - Commit/rename latency 1 cycle: visible on reads the cycle after the edge.
// - rs1==rs2 is legal; both ports return identical data.
// CONFIGURATION
// REGFILE_BYPASS_EN defined: same-cycle forwarding applies to a read port when all of the following hold:
//   - rdy_commit_rob_in is high
//   - dest_rob_in equals that port's rs index, and is non-zero
//   - tag[rs] equals rob_id_rob_in and busy[rs] is set
//   In that case the port returns busy=0, rob=0, val=value_rob_in combinationally.
// REGFILE_BYPASS_EN undefined: reads reflect registered state only; the dispatcher fetches the value from the ROB by tag.
// TESTING
// 1. Reset, then read rs1=5 -> busy=0, rob=0, val=0.
// 2. Rename x5->3; next cycle read x5 -> busy=1, rob=3.
//    Commit (x5, 0x1234, id 3): next cycle busy=0, val=0x1234.
//    With BYPASS_EN: busy=0, val=0x1234 already in the commit cycle.
// 3. Rename x5->3, then rename x5->7; commit (x5, 0xAA, id 3) -> val=0xAA, busy=1, rob=7.
// 4. Same cycle: commit (x6, 0x55, id 4) with tag[x6]=4, and rename x6->9 -> next cycle val=0x55, busy=1, rob=9.
// 5. Rename x0->2 and commit (x0, 5, id 2) -> x0 reads busy=0, rob=0, val=0.
// 6. Regs x1,x2,x3 busy; refresh with commit (x1, 0x100, id tag[x1]) and rename x4->5 in the same cycle ->
//    all busy=0, x1=0x100, x4 not busy.
//    Also hold rdy_in=0 with commit asserted -> no state change.

Source files
------------

// File: rtl/reg_file_rename.sv
// Architectural register file plus rename table (busy bit + ROB tag per register).
// Optional same-cycle commit forwarding on the read ports: define REGFILE_BYPASS_EN.
module reg_file_rename #(
    parameter int REG_NUM = 32,
    parameter int REG_W   = 5,
    parameter int DATA_W  = 32,
    parameter int ROB_W   = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              rdy_commit_rob_in,
    input  logic [REG_W-1:0]  dest_rob_in,
    input  logic [DATA_W-1:0] value_rob_in,
    input  logic [ROB_W-1:0]  rob_id_rob_in,
    input  logic              refresh_cdb_in,
    input  logic              rdy_dp_in,
    input  logic [REG_W-1:0]  rd_dp_in,
    input  logic [ROB_W-1:0]  rob_id_dp_in,
    input  logic [REG_W-1:0]  rs1_dp_in,
    input  logic [REG_W-1:0]  rs2_dp_in,
    output logic              rs1_busy_dp_out,
    output logic [ROB_W-1:0]  rs1_rob_dp_out,
    output logic [DATA_W-1:0] rs1_val_dp_out,
    output logic              rs2_busy_dp_out,
    output logic [ROB_W-1:0]  rs2_rob_dp_out,
    output logic [DATA_W-1:0] rs2_val_dp_out
);

    logic [DATA_W-1:0]  r_val [REG_NUM];
    logic [REG_NUM-1:0] r_busy;
    logic [ROB_W-1:0]   r_tag [REG_NUM];

    logic [REG_NUM-1:0] w_cmt_hit;
    logic [REG_NUM-1:0] w_ren_hit;

    // x0 never matches, so it is never written and never becomes busy.
    always_comb begin
        w_cmt_hit = '0;
        w_ren_hit = '0;
        for (int i = 1; i < REG_NUM; i++) begin
            w_cmt_hit[i] = rdy_commit_rob_in && (dest_rob_in == REG_W'(i));
            w_ren_hit[i] = rdy_dp_in && (rd_dp_in == REG_W'(i));
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_busy <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                r_val[i] <= '0;
                r_tag[i] <= '0;
            end
        end else if (rdy_in) begin
            for (int i = 1; i < REG_NUM; i++) begin
                if (w_cmt_hit[i])
                    r_val[i] <= value_rob_in;
                // A rename in the same cycle supersedes the retiring producer.
                if (refresh_cdb_in) begin
                    r_busy[i] <= 1'b0;
                    r_tag[i]  <= '0;
                end else if (w_ren_hit[i]) begin
                    r_busy[i] <= 1'b1;
                    r_tag[i]  <= rob_id_dp_in;
                end else if (w_cmt_hit[i] && (r_tag[i] == rob_id_rob_in)) begin
                    r_busy[i] <= 1'b0;
                    r_tag[i]  <= '0;
                end
            end
        end
    end

    logic [REG_W-1:0]  w_rs_idx  [2];
    logic              w_rd_busy [2];
    logic [ROB_W-1:0]  w_rd_rob  [2];
    logic [DATA_W-1:0] w_rd_val  [2];

    assign w_rs_idx[0] = rs1_dp_in;
    assign w_rs_idx[1] = rs2_dp_in;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rd_busy[p] = 1'b0;
            w_rd_rob[p]  = '0;
            w_rd_val[p]  = '0;
            if (w_rs_idx[p] != '0) begin
                w_rd_busy[p] = r_busy[w_rs_idx[p]];
                w_rd_rob[p]  = r_tag[w_rs_idx[p]];
                w_rd_val[p]  = r_val[w_rs_idx[p]];
`ifdef REGFILE_BYPASS_EN
                // Latest producer is retiring right now: hand its value straight through.
                if (rdy_commit_rob_in && (dest_rob_in == w_rs_idx[p]) &&
                    r_busy[w_rs_idx[p]] && (r_tag[w_rs_idx[p]] == rob_id_rob_in)) begin
                    w_rd_busy[p] = 1'b0;
                    w_rd_rob[p]  = '0;
                    w_rd_val[p]  = value_rob_in;
                end
`endif
            end
        end
    end

    assign rs1_busy_dp_out = w_rd_busy[0];
    assign rs1_rob_dp_out  = w_rd_rob[0];
    assign rs1_val_dp_out  = w_rd_val[0];
    assign rs2_busy_dp_out = w_rd_busy[1];
    assign rs2_rob_dp_out  = w_rd_rob[1];
    assign rs2_val_dp_out  = w_rd_val[1];

endmodule
